// File: rtl/aer_link_arbiter_pkg.sv
// Shared AER link definitions: address width, arbiter state encoding and default sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pa_SnnAccelerator;

    localparam int M               = 8;     // AER address width
    localparam int NREQ_DEFAULT    = 4;     // event sources sharing one link
    localparam int TIMEOUT_DEFAULT = 1024;  // cycles to wait for an ACK edge, 0 = wait forever

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO
    } aer_arb_state_t;

endpackage

// File: rtl/aer_ack_sync.sv
// Two-flop synchroniser for an asynchronous AER handshake line.
// Latency: input visible on sync_out after two clk edges.
// Backpressure: none; samples every cycle.
// Ports: clk/rst (async active-high, clears to 0), async_in (raw line), sync_out (clk-domain copy).
module aer_ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/aer_link_arbiter.sv
// Round-robin arbiter sharing one 4-phase AER output link between NREQ event sources.
// Latency: grant one edge after SRC_VALID; ACK seen through a 2-flop synchroniser; one IDLE cycle between handshakes.
// Backpressure: a source holds SRC_VALID/SRC_ADDR until its SRC_READY pulse; a dead receiver aborts after TIMEOUT cycles.
// Ports: CLK/RST; SRC_VALID/SRC_ADDR/SRC_READY per-source request side; AEROUT_ADDR/REQ/ACK link side;
//        GNT_ID current owner, BUSY handshake in progress, ERR_TIMEOUT sticky abort flag.
module aer_link_arbiter #(
    parameter int M       = pa_SnnAccelerator::M,
    parameter int NREQ    = pa_SnnAccelerator::NREQ_DEFAULT,
    parameter int TIMEOUT = pa_SnnAccelerator::TIMEOUT_DEFAULT,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   SRC_VALID,
    input  logic [NREQ*M-1:0] SRC_ADDR,
    output logic [NREQ-1:0]   SRC_READY,
    output logic [M-1:0]      AEROUT_ADDR,
    output logic              AEROUT_REQ,
    input  logic              AEROUT_ACK,
    output logic [IW-1:0]     GNT_ID,
    output logic              BUSY,
    output logic              ERR_TIMEOUT
);

    import pa_SnnAccelerator::aer_arb_state_t;
    import pa_SnnAccelerator::IDLE;
    import pa_SnnAccelerator::WAIT_HI;
    import pa_SnnAccelerator::WAIT_LO;

    // A width-1 counter keeps the declarations legal when the timeout is disabled.
    localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    aer_arb_state_t  state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [M-1:0]    addr_q, addr_d;
    logic [NREQ-1:0] rdy_q, rdy_d;
    logic            req_q, req_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ack_s;
    logic            timed_out;
    logic [IW:0]     pick;
    logic [IW-1:0]   win;
    logic [M-1:0]    src_addr_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign src_addr_a[g] = SRC_ADDR[g*M +: M];
    end

    aer_ack_sync u_ack_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (AEROUT_ACK),
        .sync_out (ack_s)
    );

    // Returns {found, index} of the first set bit at or above p, wrapping modulo NREQ.
    // Walking offsets from high to low lets the nearest candidate overwrite the others.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IW-1:0] p);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (v[IW'(idx)]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    assign pick      = rr_pick(SRC_VALID, ptr_q);
    assign win       = pick[IW-1:0];
    assign timed_out = (TIMEOUT > 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        rdy_d   = '0;
        req_d   = req_q;
        busy_d  = busy_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // A still-high ACK (e.g. after an abort in WAIT_LO) blocks new grants.
                if (!ack_s && pick[IW]) begin
                    addr_d     = src_addr_a[win];
                    req_d      = 1'b1;
                    gnt_d      = win;
                    busy_d     = 1'b1;
                    rdy_d[win] = 1'b1;
                    ptr_d      = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI, WAIT_LO: begin
                if ((state_q == WAIT_HI) ? ack_s : !ack_s) begin
                    cnt_d = '0;
                    if (state_q == WAIT_HI) begin
                        req_d   = 1'b0;
                        state_d = WAIT_LO;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (timed_out) begin
                    // READY has already pulsed, so the event is dropped rather than retried.
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            rdy_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            rdy_q   <= rdy_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign SRC_READY   = rdy_q;
    assign AEROUT_ADDR = addr_q;
    assign AEROUT_REQ  = req_q;
    assign GNT_ID      = gnt_q;
    assign BUSY        = busy_q;
    assign ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_aer_link_arbiter.sv
// Directed self-checking bench for aer_link_arbiter (M=8, NREQ=4, TIMEOUT=16).
// Latency: inputs driven and outputs sampled just after each falling clock edge.
// Backpressure: the bench plays the receiver by driving AEROUT_ACK directly.
module tb_aer_link_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  SRC_VALID;
    logic [31:0] SRC_ADDR;
    logic [3:0]  SRC_READY;
    logic [7:0]  AEROUT_ADDR;
    logic        AEROUT_REQ;
    logic        AEROUT_ACK;
    logic [1:0]  GNT_ID;
    logic        BUSY;
    logic        ERR_TIMEOUT;

    int checks   = 0;
    int failures = 0;

    aer_link_arbiter #(.M(8), .NREQ(4), .TIMEOUT(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SRC_VALID   (SRC_VALID),
        .SRC_ADDR    (SRC_ADDR),
        .SRC_READY   (SRC_READY),
        .AEROUT_ADDR (AEROUT_ADDR),
        .AEROUT_REQ  (AEROUT_REQ),
        .AEROUT_ACK  (AEROUT_ACK),
        .GNT_ID      (GNT_ID),
        .BUSY        (BUSY),
        .ERR_TIMEOUT (ERR_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (SRC_READY == 4'b0 && n < 40);
        check(tag, 32'(SRC_READY != 4'b0), 1);
    endtask

    task automatic wait_req_low(input string tag);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (AEROUT_REQ && n < 40);
        check(tag, 32'(AEROUT_REQ), 0);
    endtask

    // Receiver completes a handshake: ACK up, REQ falls 3 edges later; ACK down, BUSY clears 3 edges later.
    task automatic handshake(input string tag);
        AEROUT_ACK = 1'b1;
        step(3);
        check({tag, "_req_low"}, 32'(AEROUT_REQ), 0);
        AEROUT_ACK = 1'b0;
        step(3);
        check({tag, "_busy_low"}, 32'(BUSY), 0);
    endtask

    initial begin
        int exp_id;

        RST        = 1'b1;
        SRC_VALID  = '0;
        SRC_ADDR   = '0;
        AEROUT_ACK = 1'b0;
        step(2);
        check("rst_req",   32'(AEROUT_REQ),  0);
        check("rst_addr",  32'(AEROUT_ADDR), 0);
        check("rst_ready", 32'(SRC_READY),   0);
        check("rst_gnt",   32'(GNT_ID),      0);
        check("rst_busy",  32'(BUSY),        0);
        check("rst_err",   32'(ERR_TIMEOUT), 0);
        RST = 1'b0;
        step(1);

        // Single request from source 1.
        SRC_ADDR[15:8] = 8'h5A;
        SRC_VALID      = 4'b0010;
        step(1);
        check("t1_ready", 32'(SRC_READY),   'h2);
        check("t1_req",   32'(AEROUT_REQ),  1);
        check("t1_addr",  32'(AEROUT_ADDR), 'h5A);
        check("t1_gnt",   32'(GNT_ID),      1);
        check("t1_busy",  32'(BUSY),        1);
        SRC_VALID = '0;
        step(1);
        check("t1_ready_pulse", 32'(SRC_READY), 0);
        step(1);
        AEROUT_ACK = 1'b1;
        step(2);
        check("t1_req_hold", 32'(AEROUT_REQ), 1);
        step(1);
        check("t1_req_fall",  32'(AEROUT_REQ),  0);
        check("t1_busy_mid",  32'(BUSY),        1);
        check("t1_addr_hold", 32'(AEROUT_ADDR), 'h5A);
        AEROUT_ACK = 1'b0;
        step(2);
        check("t1_busy_hold", 32'(BUSY), 1);
        step(1);
        check("t1_busy_clr", 32'(BUSY), 0);

        // All four valid from ptr=0: grants 0,1,2,3,0.
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) SRC_ADDR[i*8 +: 8] = 8'(8'h10 + i);
        SRC_VALID = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_id = i % 4;
            wait_ready("t2_ready_seen");
            check("t2_gnt",   32'(GNT_ID),      32'(exp_id));
            check("t2_addr",  32'(AEROUT_ADDR), 32'('h10 + exp_id));
            check("t2_ready", 32'(SRC_READY),   32'(1 << exp_id));
            if (i == 4) SRC_VALID = '0;
            step(2);
            AEROUT_ACK = 1'b1;
            wait_req_low("t2_req_low");
            AEROUT_ACK = 1'b0;
        end
        step(3);
        check("t2_busy_end", 32'(BUSY), 0);

        // Dead receiver: abort exactly 16 cycles after entering WAIT_HI.
        SRC_ADDR[23:16] = 8'hC3;
        SRC_VALID       = 4'b0100;
        step(1);
        check("t3_gnt", 32'(GNT_ID),     2);
        check("t3_req", 32'(AEROUT_REQ), 1);
        SRC_VALID = '0;
        step(15);
        check("t3_req_before", 32'(AEROUT_REQ),  1);
        check("t3_err_before", 32'(ERR_TIMEOUT), 0);
        step(1);
        check("t3_req_abort",  32'(AEROUT_REQ),  0);
        check("t3_err_set",    32'(ERR_TIMEOUT), 1);
        check("t3_busy_abort", 32'(BUSY),        0);
        step(5);
        check("t3_err_sticky", 32'(ERR_TIMEOUT), 1);
        SRC_ADDR[7:0] = 8'h33;
        SRC_VALID     = 4'b0001;
        step(1);
        check("t3_next_ready", 32'(SRC_READY),   'h1);
        check("t3_next_gnt",   32'(GNT_ID),      0);
        check("t3_next_addr",  32'(AEROUT_ADDR), 'h33);
        SRC_VALID = '0;
        handshake("t3_hs");
        check("t3_err_kept", 32'(ERR_TIMEOUT), 1);

        // Abort in WAIT_LO with ACK stuck high; grants blocked until ACK releases.
        SRC_ADDR[15:8] = 8'h77;
        SRC_VALID      = 4'b0010;
        step(1);
        check("t4_gnt", 32'(GNT_ID), 1);
        SRC_VALID  = '0;
        AEROUT_ACK = 1'b1;
        step(3);
        check("t4_req_low", 32'(AEROUT_REQ), 0);
        check("t4_busy_lo", 32'(BUSY),       1);
        step(15);
        check("t4_busy_before", 32'(BUSY), 1);
        step(1);
        check("t4_busy_abort", 32'(BUSY), 0);
        SRC_ADDR[23:16] = 8'hA5;
        SRC_VALID       = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t4_blocked_ready", 32'(SRC_READY),  0);
            check("t4_blocked_req",   32'(AEROUT_REQ), 0);
        end
        AEROUT_ACK = 1'b0;
        step(2);
        check("t4_ready_sync", 32'(SRC_READY), 0);
        step(1);
        check("t4_ready", 32'(SRC_READY),   'h4);
        check("t4_gnt2",  32'(GNT_ID),      2);
        check("t4_addr",  32'(AEROUT_ADDR), 'hA5);
        check("t4_req",   32'(AEROUT_REQ),  1);
        SRC_VALID = '0;
        handshake("t4_hs");

        // Reset during WAIT_HI: outputs clear asynchronously, ptr returns to 0.
        SRC_ADDR[15:8] = 8'h4C;
        SRC_VALID      = 4'b0010;
        step(1);
        check("t5_gnt", 32'(GNT_ID), 1);
        SRC_VALID = '0;
        step(2);
        #2 RST = 1'b1;
        #1;
        check("t5_async_req",  32'(AEROUT_REQ), 0);
        check("t5_async_busy", 32'(BUSY),       0);
        check("t5_async_gnt",  32'(GNT_ID),     0);
        SRC_ADDR[7:0]   = 8'h0F;
        SRC_ADDR[31:24] = 8'hE7;
        SRC_VALID       = 4'b1001;
        step(1);
        check("t5_rst_ready", 32'(SRC_READY), 0);
        RST = 1'b0;
        step(1);
        check("t5_ptr0_gnt",   32'(GNT_ID),    0);
        check("t5_ptr0_ready", 32'(SRC_READY), 'h1);
        SRC_VALID = 4'b1000;
        handshake("t5_hs0");
        step(1);
        check("t5_ready3", 32'(SRC_READY),   'h8);
        check("t5_gnt3",   32'(GNT_ID),      3);
        check("t5_addr3",  32'(AEROUT_ADDR), 'hE7);
        check("t5_req3",   32'(AEROUT_REQ),  1);
        SRC_VALID = '0;
        handshake("t5_hs3");

        // Wrap-around search: only source 0 valid while ptr=1.
        SRC_ADDR[7:0] = 8'h11;
        SRC_VALID     = 4'b0001;
        step(1);
        check("t6_first_gnt", 32'(GNT_ID), 0);
        SRC_VALID = '0;
        handshake("t6_hs1");
        SRC_ADDR[7:0] = 8'h22;
        SRC_VALID     = 4'b0001;
        step(1);
        check("t6_wrap_ready", 32'(SRC_READY),   'h1);
        check("t6_wrap_gnt",   32'(GNT_ID),      0);
        check("t6_wrap_addr",  32'(AEROUT_ADDR), 'h22);
        SRC_VALID = '0;
        handshake("t6_hs2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aer_link_arbiter.md
Name: aer_link_arbiter

Overview:
- Shares one outgoing 4-phase AER link between NREQ independent event sources, e.g. the image sender, the spike output path and a debug/test injector.
- Arbitration is round-robin. The block drives the REQ/ADDR side of the link and synchronises the asynchronous ACK.
- Sits between the event producers and the chip-level AER output pins, in place of a single dedicated sender.
- Provides per-requester valid/ready, a busy flag, and a sticky timeout error for a dead receiver.

Parameters:
- M, pa_SnnAccelerator::M, AER address width.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, max cycles waiting for any ACK edge before abort; 0 disables the timeout.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset; asynchronous and active-high.
- SRC_VALID  input  NREQ  per-requester event pending; must be held with address until the matching SRC_READY bit.
- SRC_ADDR  input  NREQ*M  packed addresses; requester i occupies bits [i*M +: M].
- SRC_READY  output  NREQ  one-cycle pulse; event from requester i accepted.
- AEROUT_ADDR  output  M  link address, stable while AEROUT_REQ=1.
- AEROUT_REQ  output  1  link request.
- AEROUT_ACK  input  1  link acknowledge, asynchronous.
- GNT_ID  output  clog2(NREQ)  requester owning the current transfer.
- BUSY  output  1  high from grant until the handshake completes or aborts.
- ERR_TIMEOUT  output  1  sticky abort flag; cleared only by RST.

Behaviour:
- Reset values: AEROUT_REQ=0, AEROUT_ADDR=0, SRC_READY=0, GNT_ID=0, BUSY=0, ERR_TIMEOUT=0, RR pointer=0, state=IDLE, sync flops=0.
- ACK synchroniser: 2 flops giving ack_s. All decisions use ack_s only.
- State IDLE:
  - Arbitrates only if ack_s==0 and any SRC_VALID.
  - Winner = first set bit searching from ptr upward, with modulo-NREQ wrap.
  - At the next edge: AEROUT_ADDR<=SRC_ADDR[winner], AEROUT_REQ<=1, GNT_ID<=winner, BUSY<=1, SRC_READY[winner]<=1 for exactly one cycle, ptr<=winner+1 (wrapping NREQ-1 -> 0), state<=WAIT_HI.
- State WAIT_HI: on ack_s==1, AEROUT_REQ<=0 and state<=WAIT_LO. AEROUT_ADDR holds.
- State WAIT_LO: on ack_s==0, BUSY<=0 and state<=IDLE. The next grant can issue on the following edge, so a back-to-back handshake costs one IDLE cycle.
- Timeout:
  - Counter clears on each state entry and counts in WAIT_HI/WAIT_LO.
  - On reaching TIMEOUT: AEROUT_REQ<=0, ERR_TIMEOUT<=1, BUSY<=0, state<=IDLE.
  - The event is dropped, not retried, because SRC_READY has already pulsed.
  - Counter width is clog2(TIMEOUT+1).
- Stuck-high ACK after a WAIT_LO abort: IDLE keeps blocking grants while ack_s==1. REQ is therefore never raised against a high ACK.
- SRC_VALID dropping before grant: no error. The request is simply not considered.
- Simultaneous events:
  - All valid with ptr=k: grant order is k, k+1, ...
  - A requester re-asserting right after its READY waits behind the others.
- RST mid-handshake: REQ drops immediately (asynchronous), the in-flight event is lost, and SRC_READY is not re-pulsed.
- No combinational path from SRC_* to outputs. All outputs are registered.

Decomposition:
- Package pa_SnnAccelerator:
  - M.
  - typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} aer_arb_state_t.
  - Default NREQ/TIMEOUT constants.
- Sub-module aer_ack_sync (2-flop synchroniser, async reset to 0), reused by other AER receivers/senders.
- Round-robin winner search is a function inside the arbiter.

Test Plan:
- Single request, NREQ=4, SRC_VALID=0010, addr1=8'h5A:
  - READY[1] pulses 1 cycle after valid.
  - AEROUT_REQ=1 with ADDR=5A, GNT_ID=1.
  - Receiver ACKs after 3 cycles; REQ falls 1 cycle after ack_s rises.
  - BUSY clears 1 cycle after ack_s falls.
- All four valid continuously, ptr=0, receiver with fixed 2-cycle ACK:
  - Grant sequence 0,1,2,3,0.
  - Each ADDR matches its requester; no requester is granted twice in a row.
- Receiver never ACKs, TIMEOUT=16:
  - REQ drops exactly 16 cycles after entering WAIT_HI.
  - ERR_TIMEOUT=1 and stays high; the next valid is granted normally afterwards.
- ACK held high after a WAIT_LO timeout, requester 2 valid:
  - No grant and REQ stays 0 while ACK is high.
  - Grant occurs 3 cycles after ACK is released (2 sync cycles + arbitration).
- RST pulsed during WAIT_HI:
  - REQ=0 and BUSY=0 asynchronously; ptr=0.
  - After release, pending valid requester 3 is granted with a clean handshake.
- Requester 0 valid with ptr=1 and no others valid: grant is 0 (wrap-around search).
